bcd_addsub_serial: RTL and testbench
====================================

# bcd_addsub_serial

Digit-serial, parametrised BCD adder/subtractor for multi-digit packed-BCD operands. It processes one decimal digit per clock, least significant digit first, and returns a DIGITS-wide packed-BCD result with a carry/borrow flag. Operands arrive and results leave over valid/ready handshakes. It is the area-lean, width-scalable successor to the team's fixed two-digit combinational BCD adder, and adds subtraction and invalid-digit detection.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits per operand (≥1); data width W = 4*DIGITS

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand request valid
- in_ready  out  1  block can accept a request
- a  in  W  first operand, packed BCD, digit 0 in a[3:0]
- b  in  W  second operand, packed BCD
- op  in  1  0 = add, 1 = subtract (a − b)
- cin  in  1  add: carry-in; subtract: borrow-in
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- s  out  W  packed-BCD result
- cout  out  1  add: decimal carry-out; subtract: borrow-out (1 when a < b + cin)
- err  out  1  some nibble of a or b was > 9

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready = 1. On in_valid & in_ready:
  - Latch a and b' into the shift registers. For add, b' = b. For subtract, b' = the digit-wise nines complement (9 − digit).
  - Set c0 = cin for add, c0 = !cin for subtract.
  - Latch op. Compute err from the raw a and b (any nibble > 9).
  - Clear the digit counter. Go to RUN.
- RUN: one digit per cycle, digit k at cycle k.
  - t = a_k + b'_k + c, a 5-bit sum.
  - If t > 9: s_k = (t + 6)[3:0] and c = 1. Otherwise s_k = t[3:0] and c = 0.
  - The s_k nibble shifts into the result register from the MSD end.
  - After digit DIGITS−1 is processed, go to DONE.
- DONE: out_valid = 1.
  - s holds the assembled result.
  - For add, cout = final c. For subtract, cout = !final c.
  - If err = 1, then s = 0 and cout = 0, regardless of the computed value.
  - On out_ready, go to IDLE.
- Arithmetic:
  - Add: s = (a + b + cin) mod 10^DIGITS.
  - Subtract: s = (a − b − cin) mod 10^DIGITS, i.e. the ten's complement when the result is negative.
- in_ready = 0 in RUN and DONE. There is no overlap of operations and no input buffering.
- a, b, op and cin are sampled only at acceptance. Later changes to these inputs have no effect.

## Timing
- Reset (async assert, sync deassert at the clk edge): state = IDLE, in_ready = 1, out_valid = 0, s = 0, cout = 0, err = 0, digit counter = 0.
- An assertion of rst_n in RUN or DONE aborts the operation. The pending result is discarded, never presented.
- Latency: accept at edge E0. out_valid rises after edge E0+DIGITS, i.e. DIGITS+1 cycles after the accepting cycle.
- out_valid, s, cout and err are stable while out_valid = 1 and out_ready = 0 (backpressure holds indefinitely).
- Handshake completes on the edge where out_valid & out_ready. out_valid = 0 and in_ready = 1 in the following cycle.
- Maximum throughput: one operation per DIGITS+2 cycles.
- s, cout and err are registered outputs. s, cout and err keep their last values after the handshake until the next result loads.
- DIGITS = 1: RUN lasts exactly one cycle.
- in_valid while in_ready = 0 is ignored. The requester must hold the request until it is accepted.

## Test plan
- DIGITS=4, add, a=0x1234, b=0x5678, cin=0 → s=0x6912, cout=0, err=0, out_valid 5 cycles after accept.
- Add, a=0x9999, b=0x9999, cin=1 → s=0x9999, cout=1. Add, a=0x9999, b=0x0001, cin=0 → s=0x0000, cout=1.
- Subtract, a=0x0100, b=0x0001, cin=0 → s=0x0099, cout=0. Subtract, a=0x0000, b=0x0001, cin=0 → s=0x9999, cout=1.
- Invalid digit: add, a=0x00A0, b=0x0001 → err=1, s=0x0000, cout=0. The next valid operation clears err.
- Backpressure: out_ready held low 10 cycles → outputs stable and in_ready=0 throughout. in_valid asserted in RUN is not accepted. Raise out_ready → in_ready=1 next cycle.
- Reset mid-RUN (assert rst_n at digit 2) → immediately out_valid=0, in_ready=1, s=0. A fresh 0x0005+0x0005 then gives s=0x0010, cout=0.

Source files
------------

// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD adder/subtractor: one decimal digit per clock, LSD first.
// Subtraction adds the nines complement of b with an inverted borrow as carry-in.
module bcd_addsub_serial #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   input  logic                  op,
   input  logic                  cin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   s,
   output logic                  cout,
   output logic                  err
);
   // state | meaning
   // IDLE  | waiting for an operand request, in_ready = 1
   // RUN   | processing digit cnt, one per clock
   // DONE  | result presented, waiting for out_ready
   localparam int W  = 4 * DIGITS;
   localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state;
   logic [W-1:0]    a_sh;
   logic [W-1:0]    b_sh;
   logic [W-1:0]    acc;
   logic [CW-1:0]   cnt;
   logic            c;
   logic            op_r;
   logic            err_r;

   logic [4:0]      t;
   logic [4:0]      t_adj;
   logic [3:0]      s_k;
   logic            c_next;
   logic [W-1:0]    acc_next;
   logic            last;

   function automatic logic [W-1:0] nines(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'd9 - v[4*i +: 4];
      return r;
   endfunction

   function automatic logic has_bad(input logic [W-1:0] v);
      logic r;
      r = 1'b0;
      for (int i = 0; i < DIGITS; i++) r = r | (v[4*i +: 4] > 4'd9);
      return r;
   endfunction

   always_comb begin
      t      = 5'(a_sh[3:0]) + 5'(b_sh[3:0]) + 5'(c);
      t_adj  = t + 5'd6;
      s_k    = t[3:0];
      c_next = 1'b0;
      if (t > 5'd9) begin
         s_k    = t_adj[3:0];
         c_next = 1'b1;
      end
      // new digit enters at the MSD end so digit 0 ends up in the low nibble
      acc_next = (acc >> 4) | (W'(s_k) << (W - 4));
   end

   assign last = (cnt == CW'(DIGITS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         s         <= '0;
         cout      <= 1'b0;
         err       <= 1'b0;
         a_sh      <= '0;
         b_sh      <= '0;
         acc       <= '0;
         cnt       <= '0;
         c         <= 1'b0;
         op_r      <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh     <= a;
                  b_sh     <= op ? nines(b) : b;
                  c        <= op ? ~cin : cin;
                  op_r     <= op;
                  err_r    <= has_bad(a) | has_bad(b);
                  cnt      <= '0;
                  state    <= RUN;
                  in_ready <= 1'b0;
               end
            end
            RUN: begin
               a_sh <= a_sh >> 4;
               b_sh <= b_sh >> 4;
               acc  <= acc_next;
               c    <= c_next;
               cnt  <= cnt + CW'(1);
               if (last) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  s         <= err_r ? '0 : acc_next;
                  cout      <= err_r ? 1'b0 : (op_r ? ~c_next : c_next);
                  err       <= err_r;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Randomized bench for bcd_addsub_serial against a decimal-arithmetic reference model.
module tb_bcd_addsub_serial;
   localparam int DIGITS = 4;
   localparam int W      = 4 * DIGITS;
   localparam int MODV   = 10000;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          op;
   logic          cin;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  s;
   logic          cout;
   logic          err;

   int n_chk;
   int n_fail;

   bcd_addsub_serial #(.DIGITS(DIGITS)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid),
      .out_ready(out_ready), .s(s), .cout(cout), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int bcd2int(input logic [W-1:0] v);
      int r;
      r = 0;
      for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
      return r;
   endfunction

   function automatic logic [W-1:0] int2bcd(input int v);
      logic [W-1:0] r;
      int x;
      r = '0;
      x = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic any_bad(input logic [W-1:0] v);
      logic r;
      r = 1'b0;
      for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) r = 1'b1;
      return r;
   endfunction

   task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mop,
                        input logic mcin, output logic [W-1:0] es, output logic ec,
                        output logic ee);
      int r;
      ee = any_bad(ma) | any_bad(mb);
      if (mop == 1'b0) r = bcd2int(ma) + bcd2int(mb) + int'(mcin);
      else             r = bcd2int(ma) - bcd2int(mb) - int'(mcin);
      ec = mop ? (r < 0) : (r >= MODV);
      if (r < 0) r = r + MODV;
      es = int2bcd(r % MODV);
      if (ee) begin
         es = '0;
         ec = 1'b0;
      end
   endtask

   // Full transaction: accept, latency, result, bp cycles of backpressure, handshake.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic top,
                         input logic tcin, input int bp);
      logic [W-1:0] es;
      logic         ec;
      logic         ee;
      int           lat;
      model(ta, tb_v, top, tcin, es, ec, ee);
      @(negedge clk);
      chk("ready_idle", 32'(in_ready), 32'd1);
      in_valid = 1'b1; a = ta; b = tb_v; op = top; cin = tcin;
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         // garbage request during RUN must be ignored
         in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
         op = 1'($urandom); cin = 1'($urandom);
         if (lat == 2) chk("ready_run", 32'(in_ready), 32'd0);
      end while (!out_valid && lat < 50);
      chk("latency", 32'(lat), 32'(DIGITS + 1));
      chk("s", 32'(s), 32'(es));
      chk("cout", 32'(cout), 32'(ec));
      chk("err", 32'(err), 32'(ee));
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         chk("bp_hold", {in_ready, out_valid, err, cout, 12'd0, s}, {1'b0, 1'b1, ee, ec, 12'd0, es});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("post_hs", {in_ready, out_valid, 14'd0, s}, {1'b1, 1'b0, 14'd0, es});
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      n_chk = 0; n_fail = 0;
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; cin = 1'b0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst", {in_ready, out_valid, err, cout, 12'd0, s}, 32'h8000_0000);
      rst_n = 1'b1;

      run_op(16'h1234, 16'h5678, 1'b0, 1'b0, 0);
      run_op(16'h9999, 16'h9999, 1'b0, 1'b1, 1);
      run_op(16'h9999, 16'h0001, 1'b0, 1'b0, 0);
      run_op(16'h0100, 16'h0001, 1'b1, 1'b0, 0);
      run_op(16'h0000, 16'h0001, 1'b1, 1'b0, 0);
      run_op(16'h00A0, 16'h0001, 1'b0, 1'b0, 0);
      run_op(16'h0002, 16'h0003, 1'b0, 1'b0, 10);
      run_op(16'h5000, 16'h5000, 1'b1, 1'b1, 2);

      // abort mid-RUN at digit 2
      @(negedge clk);
      in_valid = 1'b1; a = 16'h4321; b = 16'h1234; op = 1'b0; cin = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort", {in_ready, out_valid, 14'd0, s}, {1'b1, 1'b0, 14'd0, 16'h0000});
      @(negedge clk);
      rst_n = 1'b1;
      run_op(16'h0005, 16'h0005, 1'b0, 1'b0, 0);

      for (int n = 0; n < 40; n++) begin
         ra = '0; rb = '0;
         for (int i = 0; i < DIGITS; i++) begin
            ra[4*i +: 4] = 4'($urandom_range(0, 9));
            rb[4*i +: 4] = 4'($urandom_range(0, 9));
         end
         if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
         run_op(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
